// File: rtl/bsg_manycore_store_ack_endpoint_if.sv
// Bundles the ack-ingress, return-egress and return-ingress handshakes of the store-ack endpoint.
// Latency: none, wires only.
// Backpressure: ack_ready_o and ret_ready_i are carried here; ret_ready_o is a constant sink.
interface bsg_manycore_store_ack_endpoint_if #(
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5
);
  localparam int ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p;

  // Acks from local memory for accepted remote stores
  logic                           ack_v_i;
  logic [x_cord_width_p-1:0]      ack_src_x_i;
  logic [y_cord_width_p-1:0]      ack_src_y_i;
  logic                           ack_ready_o;

  // Outgoing return packets toward the router P port
  logic                           ret_v_o;
  logic [ret_packet_width_lp-1:0] ret_data_o;
  logic                           ret_ready_i;

  // Incoming return packets from the router P port
  logic                           ret_v_i;
  logic [ret_packet_width_lp-1:0] ret_data_i;
  logic                           ret_ready_o;

  // Endpoint side
  modport slave (
    input  ack_v_i, ack_src_x_i, ack_src_y_i,
    output ack_ready_o,
    output ret_v_o, ret_data_o,
    input  ret_ready_i,
    input  ret_v_i, ret_data_i,
    output ret_ready_o
  );

  // Environment side (processor, local memory, router)
  modport master (
    output ack_v_i, ack_src_x_i, ack_src_y_i,
    input  ack_ready_o,
    input  ret_v_o, ret_data_o,
    output ret_ready_i,
    output ret_v_i, ret_data_i,
    input  ret_ready_o
  );
endinterface

// File: rtl/bsg_manycore_store_ack_endpoint.sv
// Queues store-ack return packets to remote senders and counts this tile's outstanding remote stores.
// Latency: ack_v_i in cycle N -> ret_v_o in N+1; counter changes visible one cycle after the cause.
// Backpressure: ack_ready_o low only when the ack queue is full (no enqueue-on-dequeue); arriving returns always sunk.
// Optional sticky error reporting is built when BSG_MANYCORE_STORE_ACK_ERR_EN is defined.
module bsg_manycore_store_ack_endpoint #(
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5,
  parameter int ack_fifo_els_p = 4,
  parameter int count_width_p  = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bsg_manycore_store_ack_endpoint_if.slave ep,
  input  logic                     store_sent_i,
  output logic [count_width_p-1:0] outstanding_o,
  output logic                     credit_avail_o,
  output logic                     stores_done_o,
  output logic                     error_o
);
  localparam int ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p;
  localparam int addr_width_lp       = $clog2(ack_fifo_els_p);
  localparam int ptr_width_lp        = addr_width_lp + 1;
  localparam logic [4:0] op_store_ack_lp = 5'h01;

  // ---------------- ack queue ----------------
  logic [ptr_width_lp-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ret_packet_width_lp-1:0] mem_q [ack_fifo_els_p];
  logic [ret_packet_width_lp-1:0] ack_pkt;
  logic                           full, empty, enq, deq;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[addr_width_lp-1:0] == rd_ptr_q[addr_width_lp-1:0])
              && (wr_ptr_q[ptr_width_lp-1] != rd_ptr_q[ptr_width_lp-1]);

  // A full queue refuses the ack even if the head drains this cycle
  assign enq     = ep.ack_v_i & ~full;
  assign deq     = ~empty & ep.ret_ready_i;
  assign ack_pkt = {op_store_ack_lp, ep.ack_src_y_i, ep.ack_src_x_i};

  assign ep.ack_ready_o = ~full;
  assign ep.ret_v_o     = ~empty;
  assign ep.ret_data_o  = mem_q[rd_ptr_q[addr_width_lp-1:0]];
  assign ep.ret_ready_o = 1'b1;

  // Advance pointers on enqueue/dequeue handshakes
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
    if (deq) rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
  end

  // Queue storage needs no reset: stale entries are hidden by the pointers
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q[addr_width_lp-1:0]] <= ack_pkt;
  end

  // ---------------- outstanding-store counter ----------------
  logic [count_width_p-1:0] count_q, count_d;
  logic [4:0]               ret_op;
  logic                     inc, dec, at_max, at_zero;
  logic                     unused_ret_coords;

  // Coordinates of arriving returns are irrelevant here; only the op matters
  assign ret_op            = ep.ret_data_i[ret_packet_width_lp-1 -: 5];
  assign unused_ret_coords = ^ep.ret_data_i[x_cord_width_p+y_cord_width_p-1:0];

  assign inc     = store_sent_i;
  assign dec     = ep.ret_v_i & (ret_op == op_store_ack_lp);
  assign at_max  = (count_q == {count_width_p{1'b1}});
  assign at_zero = (count_q == '0);

  // Saturating up/down count; simultaneous inc and dec cancel
  always_comb begin
    count_d = count_q;
    if (inc & ~dec & ~at_max)       count_d = count_q + count_width_p'(1);
    else if (dec & ~inc & ~at_zero) count_d = count_q - count_width_p'(1);
  end

  assign outstanding_o  = count_q;
  assign credit_avail_o = ~at_max;
  assign stores_done_o  = at_zero;

  // Pointer and counter state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------- protocol error reporting ----------------
`ifdef BSG_MANYCORE_STORE_ACK_ERR_EN
  logic err_q, err_d;
  logic overflow, underflow, bad_op, drop;

  assign overflow  = inc & ~dec & at_max;
  assign underflow = dec & ~inc & at_zero;
  assign bad_op    = ep.ret_v_i & (ret_op != op_store_ack_lp);
  assign drop      = ep.ack_v_i & full;

  // Sticky: any violation latches until reset
  always_comb begin
    err_d = err_q | overflow | underflow | bad_op | drop;
  end

  // Error flag register
  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign error_o = err_q;

`ifndef SYNTHESIS
  // Report each violation with its cause for simulation debug
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (overflow)  $display("%0t: store-ack endpoint: counter overflow", $time);
      if (underflow) $display("%0t: store-ack endpoint: counter underflow", $time);
      if (bad_op)    $display("%0t: store-ack endpoint: unknown return op %0h", $time, ret_op);
      if (drop)      $display("%0t: store-ack endpoint: ack dropped, queue full", $time);
    end
  end
`endif
`else
  assign error_o = 1'b0;
`endif

endmodule
